mips_bus_arbiter: RTL and testbench

- Shares the single Avalon-style memory bus of mips_cpu_bus between two requesters: the instruction-fetch port (f_) and the load/store data port (d_).
- Arbitration is round-robin. A grant is held for the full transaction, including waitrequest stalls and a 1-cycle read-data return.
- A watchdog flags a slave that stalls for too long.
- Sits between the CPU core and the bus pins (address, read, write, writedata, byteenable, waitrequest, readdata).

---
 rtl/mips_bus_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_mips_bus_arbiter.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter
//   Shares the single Avalon-style memory bus between the instruction-fetch
//   port (f_) and the load/store data port (d_). Round-robin arbitration; a
//   grant is held for the whole transaction, including slave stalls and the
//   one-cycle read-data return. A watchdog raises a sticky bus_error when the
//   slave stalls a granted access for TIMEOUT consecutive cycles.
//
// Ports
//   clk, reset                 system clock, synchronous active-high reset
//   f_address/f_read           fetch request (always full-word read)
//   f_waitrequest              fetch stall, low when the bus accepts the read
//   f_readdata/f_readdatavalid fetch return data, valid for one cycle
//   d_address/d_read/d_write   data request
//   d_writedata/d_byteenable   store data and byte lanes
//   d_waitrequest              data stall, low when the bus accepts the access
//   d_readdata/d_readdatavalid data return data, valid for one cycle
//   address/read/write/
//   writedata/byteenable       bus master outputs toward the slave
//   waitrequest                slave stall
//   readdata                   slave read data, valid the cycle after accept
//   bus_error                  sticky watchdog flag, cleared only by reset
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no grant; bus outputs 0; choose the next requester
// BUSY_F | fetch port granted; bus mirrors the fetch request
// BUSY_D | data port granted; bus mirrors the data request
// RESP_F | read accepted last cycle; return readdata to the fetch port
// RESP_D | read accepted last cycle; return readdata to the data port

module mips_bus_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        reset,

  input  logic [31:0] f_address,
  input  logic        f_read,
  output logic        f_waitrequest,
  output logic [31:0] f_readdata,
  output logic        f_readdatavalid,

  input  logic [31:0] d_address,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic        d_waitrequest,
  output logic [31:0] d_readdata,
  output logic        d_readdatavalid,

  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,

  output logic        bus_error
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] BUSY_F = 3'd1;
  localparam logic [2:0] BUSY_D = 3'd2;
  localparam logic [2:0] RESP_F = 3'd3;
  localparam logic [2:0] RESP_D = 3'd4;

  localparam logic GRANT_F = 1'b0;
  localparam logic GRANT_D = 1'b1;

  localparam logic [CNT_W-1:0] STALL_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(TIMEOUT - 1);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic             last_grant;
  logic             last_grant_nxt;
  logic [CNT_W-1:0] stall_cnt;

  logic f_pending;
  logic d_pending;
  logic busy;
  logic stalled;

  assign f_pending = f_read;
  assign d_pending = d_read | d_write;
  assign busy      = (state == BUSY_F) || (state == BUSY_D);
  // Only a live access counts as a stall; an aborting requester does not.
  assign stalled   = busy && (read || write) && waitrequest;

  // Next-state and arbitration
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    unique case (state)
      IDLE: begin
        // On contention the port that was not served last wins.
        if (f_pending && (!d_pending || (last_grant == GRANT_D))) begin
          state_nxt      = BUSY_F;
          last_grant_nxt = GRANT_F;
        end else if (d_pending) begin
          state_nxt      = BUSY_D;
          last_grant_nxt = GRANT_D;
        end
      end
      BUSY_F: begin
        if (!f_read)
          state_nxt = IDLE;
        else if (!waitrequest)
          state_nxt = RESP_F;
      end
      BUSY_D: begin
        if (!d_read && !d_write)
          state_nxt = IDLE;
        else if (!waitrequest)
          // read+write together is treated as a write, so no data returns
          state_nxt = d_write ? IDLE : RESP_D;
      end
      RESP_F:  state_nxt = IDLE;
      RESP_D:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GRANT_D;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Bus and requester outputs. Gating with reset makes the slave see
  // read/write drop in the same cycle reset is raised, and suppresses a
  // read-data return that would otherwise coincide with reset.
  always_comb begin
    address         = '0;
    read            = 1'b0;
    write           = 1'b0;
    writedata       = '0;
    byteenable      = '0;
    f_waitrequest   = 1'b1;
    d_waitrequest   = 1'b1;
    f_readdata      = '0;
    d_readdata      = '0;
    f_readdatavalid = 1'b0;
    d_readdatavalid = 1'b0;
    if (!reset) begin
      unique case (state)
        BUSY_F: begin
          address       = f_address;
          read          = f_read;
          byteenable    = 4'b1111;
          f_waitrequest = waitrequest;
        end
        BUSY_D: begin
          address       = d_address;
          write         = d_write;
          read          = d_read & ~d_write;
          writedata     = d_writedata;
          byteenable    = d_byteenable;
          d_waitrequest = waitrequest;
        end
        RESP_F: begin
          f_readdatavalid = 1'b1;
          f_readdata      = readdata;
        end
        RESP_D: begin
          d_readdatavalid = 1'b1;
          d_readdata      = readdata;
        end
        default: ;
      endcase
    end
  end

  // Watchdog: counts consecutive stalled cycles, saturating at TIMEOUT.
  // bus_error is set on the same edge the count reaches TIMEOUT.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      bus_error <= 1'b0;
    end else if (stalled) begin
      if (stall_cnt != STALL_MAX)
        stall_cnt <= stall_cnt + 1'b1;
      if (stall_cnt == STALL_LAST)
        bus_error <= 1'b1;
    end else begin
      stall_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed testbench for mips_bus_arbiter. Inputs are driven 1 time unit
// after each rising edge and outputs sampled 1 unit later.

module tb_mips_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] f_address = '0;
  logic        f_read = 1'b0;
  logic        f_waitrequest;
  logic [31:0] f_readdata;
  logic        f_readdatavalid;
  logic [31:0] d_address = '0;
  logic        d_read = 1'b0;
  logic        d_write = 1'b0;
  logic [31:0] d_writedata = '0;
  logic [3:0]  d_byteenable = '0;
  logic        d_waitrequest;
  logic [31:0] d_readdata;
  logic        d_readdatavalid;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest = 1'b0;
  logic [31:0] readdata = '0;
  logic        bus_error;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mips_bus_arbiter #(.TIMEOUT(64), .CNT_W(7)) dut (
    .clk             (clk),
    .reset           (reset),
    .f_address       (f_address),
    .f_read          (f_read),
    .f_waitrequest   (f_waitrequest),
    .f_readdata      (f_readdata),
    .f_readdatavalid (f_readdatavalid),
    .d_address       (d_address),
    .d_read          (d_read),
    .d_write         (d_write),
    .d_writedata     (d_writedata),
    .d_byteenable    (d_byteenable),
    .d_waitrequest   (d_waitrequest),
    .d_readdata      (d_readdata),
    .d_readdatavalid (d_readdatavalid),
    .address         (address),
    .read            (read),
    .write           (write),
    .writedata       (writedata),
    .byteenable      (byteenable),
    .waitrequest     (waitrequest),
    .readdata        (readdata),
    .bus_error       (bus_error)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    f_address    = '0;
    f_read       = 1'b0;
    d_address    = '0;
    d_read       = 1'b0;
    d_write      = 1'b0;
    d_writedata  = '0;
    d_byteenable = '0;
    waitrequest  = 1'b0;
    readdata     = '0;
  endtask

  // Leaves the bench in cycle 0 with the DUT in IDLE and reset low.
  task automatic reset_dut();
    step();
    reset = 1'b1;
    clear_inputs();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    f_address = 32'hBFC0_0000;
    f_read    = 1'b1;
    d_write   = 1'b1;
    d_writedata = 32'h5555_AAAA;
    d_byteenable = 4'hF;
    readdata  = 32'h1234_5678;
    step();
    #1;
    n_checks++;
    if ({read, write, address, writedata, byteenable} !== 70'h0) begin
      n_fail++;
      $display("FAIL reset_bus_outputs: got %h expected 0", {read, write, address, writedata, byteenable});
    end
    n_checks++;
    if ({f_waitrequest, d_waitrequest, f_readdatavalid, d_readdatavalid, bus_error} !== 5'b11000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 11000", {f_waitrequest, d_waitrequest, f_readdatavalid, d_readdatavalid, bus_error});
    end
    n_checks++;
    if ({f_readdata, d_readdata} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_readdata: got %h expected 0", {f_readdata, d_readdata});
    end
    clear_inputs();
    step();
    reset = 1'b0;
    #1;
    n_checks++;
    if ({read, write, address, f_waitrequest, d_waitrequest} !== 36'h3) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %h expected 3", {read, write, address, f_waitrequest, d_waitrequest});
    end
  endtask

  task automatic test_fetch_read();
    reset_dut();
    f_address   = 32'hBFC0_0000;
    f_read      = 1'b1;
    waitrequest = 1'b0;
    #1;
    n_checks++;
    if ({read, f_waitrequest} !== 2'b01) begin
      n_fail++;
      $display("FAIL fetch_c0_idle: got %b expected 01", {read, f_waitrequest});
    end
    step();
    #1;
    n_checks++;
    if ({read, write, address, byteenable} !== {1'b1, 1'b0, 32'hBFC0_0000, 4'hF}) begin
      n_fail++;
      $display("FAIL fetch_c1_bus: got %h expected %h", {read, write, address, byteenable}, {1'b1, 1'b0, 32'hBFC0_0000, 4'hF});
    end
    n_checks++;
    if ({f_waitrequest, d_waitrequest} !== 2'b01) begin
      n_fail++;
      $display("FAIL fetch_c1_wait: got %b expected 01", {f_waitrequest, d_waitrequest});
    end
    step();
    f_read   = 1'b0;
    readdata = 32'h2402_0001;
    #1;
    n_checks++;
    if ({f_readdatavalid, d_readdatavalid, f_readdata} !== {2'b10, 32'h2402_0001}) begin
      n_fail++;
      $display("FAIL fetch_c2_data: got %h expected %h", {f_readdatavalid, d_readdatavalid, f_readdata}, {2'b10, 32'h2402_0001});
    end
    n_checks++;
    if ({read, d_waitrequest, f_waitrequest} !== 3'b011) begin
      n_fail++;
      $display("FAIL fetch_c2_bus: got %b expected 011", {read, d_waitrequest, f_waitrequest});
    end
    step();
    #1;
    n_checks++;
    if ({f_readdatavalid, f_readdata} !== 33'h0) begin
      n_fail++;
      $display("FAIL fetch_c3_idle: got %h expected 0", {f_readdatavalid, f_readdata});
    end
  endtask

  task automatic test_data_write_stall();
    logic rdv_seen;
    logic exp_dw;
    reset_dut();
    rdv_seen     = 1'b0;
    d_address    = 32'h0000_0040;
    d_write      = 1'b1;
    d_writedata  = 32'hDEAD_BEEF;
    d_byteenable = 4'b0011;
    waitrequest  = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      waitrequest = (k < 4);
      exp_dw      = (k < 4);
      #1;
      rdv_seen = rdv_seen | f_readdatavalid | d_readdatavalid;
      n_checks++;
      if ({write, read, writedata, byteenable, address} !== {1'b1, 1'b0, 32'hDEAD_BEEF, 4'b0011, 32'h0000_0040}) begin
        n_fail++;
        $display("FAIL write_stall_bus c%0d: got %h expected %h", k, {write, read, writedata, byteenable, address}, {1'b1, 1'b0, 32'hDEAD_BEEF, 4'b0011, 32'h0000_0040});
      end
      n_checks++;
      if ({d_waitrequest, f_waitrequest} !== {exp_dw, 1'b1}) begin
        n_fail++;
        $display("FAIL write_stall_wait c%0d: got %b expected %b", k, {d_waitrequest, f_waitrequest}, {exp_dw, 1'b1});
      end
    end
    step();
    d_write = 1'b0;
    #1;
    rdv_seen = rdv_seen | f_readdatavalid | d_readdatavalid;
    n_checks++;
    if ({write, d_waitrequest} !== 2'b01) begin
      n_fail++;
      $display("FAIL write_done_idle: got %b expected 01", {write, d_waitrequest});
    end
    n_checks++;
    if (rdv_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL write_no_rdv: got %b expected 0", rdv_seen);
    end
  endtask

  task automatic test_fairness();
    // {f_waitrequest, d_waitrequest, f_readdatavalid, d_readdatavalid}
    logic [3:0]  exp_fair [0:12];
    logic [3:0]  e;
    logic [31:0] exp_addr;
    logic        exp_read;
    int          f_pulses;
    int          d_pulses;
    exp_fair = '{4'hC, 4'h4, 4'hE, 4'hC, 4'h8, 4'hD, 4'hC, 4'h4, 4'hE, 4'hC, 4'h8, 4'hD, 4'hC};
    f_pulses = 0;
    d_pulses = 0;
    reset_dut();
    f_address   = 32'h0000_0100;
    d_address   = 32'h0000_0200;
    f_read      = 1'b1;
    d_read      = 1'b1;
    waitrequest = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) step();
      readdata = 32'hC0DE_0000 + k;
      #1;
      e = exp_fair[k];
      exp_read = !e[3] || !e[2];
      exp_addr = !e[3] ? 32'h0000_0100 : (!e[2] ? 32'h0000_0200 : 32'h0);
      n_checks++;
      if ({f_waitrequest, d_waitrequest, f_readdatavalid, d_readdatavalid} !== e) begin
        n_fail++;
        $display("FAIL fair_handshake c%0d: got %b expected %b", k, {f_waitrequest, d_waitrequest, f_readdatavalid, d_readdatavalid}, e);
      end
      n_checks++;
      if ({read, address} !== {exp_read, exp_addr}) begin
        n_fail++;
        $display("FAIL fair_bus c%0d: got %h expected %h", k, {read, address}, {exp_read, exp_addr});
      end
      if (e[1]) begin
        n_checks++;
        if (f_readdata !== 32'hC0DE_0000 + k) begin
          n_fail++;
          $display("FAIL fair_f_data c%0d: got %h expected %h", k, f_readdata, 32'hC0DE_0000 + k);
        end
      end
      if (e[0]) begin
        n_checks++;
        if (d_readdata !== 32'hC0DE_0000 + k) begin
          n_fail++;
          $display("FAIL fair_d_data c%0d: got %h expected %h", k, d_readdata, 32'hC0DE_0000 + k);
        end
      end
      if (f_readdatavalid === 1'b1) f_pulses++;
      if (d_readdatavalid === 1'b1) d_pulses++;
    end
    n_checks++;
    if (f_pulses != 2 || d_pulses != 2) begin
      n_fail++;
      $display("FAIL fair_pulses: got f=%0d d=%0d expected f=2 d=2", f_pulses, d_pulses);
    end
  endtask

  task automatic test_watchdog();
    logic early;
    logic dropped;
    reset_dut();
    early       = 1'b0;
    dropped     = 1'b0;
    f_address   = 32'h0000_0300;
    f_read      = 1'b1;
    waitrequest = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      step();
      #1;
      if (bus_error !== 1'b0) early = 1'b1;
      if (read !== 1'b1) dropped = 1'b1;
    end
    n_checks++;
    if (early !== 1'b0) begin
      n_fail++;
      $display("FAIL wdog_early: got %b expected 0", early);
    end
    n_checks++;
    if (dropped !== 1'b0) begin
      n_fail++;
      $display("FAIL wdog_read_held: got dropped=%b expected 0", dropped);
    end
    step();
    waitrequest = 1'b0;
    #1;
    n_checks++;
    if ({bus_error, read, f_waitrequest} !== 3'b110) begin
      n_fail++;
      $display("FAIL wdog_raised: got %b expected 110", {bus_error, read, f_waitrequest});
    end
    step();
    f_read   = 1'b0;
    readdata = 32'h600D_F00D;
    #1;
    n_checks++;
    if ({bus_error, f_readdatavalid, f_readdata} !== {2'b11, 32'h600D_F00D}) begin
      n_fail++;
      $display("FAIL wdog_completes: got %h expected %h", {bus_error, f_readdatavalid, f_readdata}, {2'b11, 32'h600D_F00D});
    end
    step();
    #1;
    n_checks++;
    if ({bus_error, f_readdatavalid} !== 2'b10) begin
      n_fail++;
      $display("FAIL wdog_sticky: got %b expected 10", {bus_error, f_readdatavalid});
    end
  endtask

  // Runs straight after the watchdog test so bus_error is still set.
  task automatic test_reset_in_resp_d();
    step();
    clear_inputs();
    d_address   = 32'h0000_0400;
    d_read      = 1'b1;
    waitrequest = 1'b0;
    step();
    #1;
    n_checks++;
    if ({read, d_waitrequest} !== 2'b10) begin
      n_fail++;
      $display("FAIL rst_resp_busy: got %b expected 10", {read, d_waitrequest});
    end
    step();
    d_read   = 1'b0;
    readdata = 32'h1234_5678;
    reset    = 1'b1;
    #1;
    n_checks++;
    if ({d_readdatavalid, d_readdata} !== 33'h0) begin
      n_fail++;
      $display("FAIL rst_resp_no_rdv: got %h expected 0", {d_readdatavalid, d_readdata});
    end
    n_checks++;
    if ({read, d_waitrequest, f_waitrequest} !== 3'b011) begin
      n_fail++;
      $display("FAIL rst_resp_bus: got %b expected 011", {read, d_waitrequest, f_waitrequest});
    end
    step();
    reset = 1'b0;
    #1;
    n_checks++;
    if ({read, write, address, writedata, byteenable} !== 70'h0) begin
      n_fail++;
      $display("FAIL rst_after_bus: got %h expected 0", {read, write, address, writedata, byteenable});
    end
    n_checks++;
    if ({f_waitrequest, d_waitrequest, f_readdatavalid, d_readdatavalid, bus_error} !== 5'b11000) begin
      n_fail++;
      $display("FAIL rst_after_flags: got %b expected 11000", {f_waitrequest, d_waitrequest, f_readdatavalid, d_readdatavalid, bus_error});
    end
  endtask

  task automatic test_read_write_both();
    reset_dut();
    d_address    = 32'h0000_0500;
    d_read       = 1'b1;
    d_write      = 1'b1;
    d_writedata  = 32'hCAFE_F00D;
    d_byteenable = 4'hF;
    waitrequest  = 1'b0;
    step();
    #1;
    n_checks++;
    if ({write, read, writedata, d_waitrequest} !== {2'b10, 32'hCAFE_F00D, 1'b0}) begin
      n_fail++;
      $display("FAIL rw_both_bus: got %h expected %h", {write, read, writedata, d_waitrequest}, {2'b10, 32'hCAFE_F00D, 1'b0});
    end
    step();
    clear_inputs();
    readdata = 32'hFFFF_0000;
    #1;
    n_checks++;
    if ({d_readdatavalid, write, d_waitrequest} !== 3'b001) begin
      n_fail++;
      $display("FAIL rw_both_no_rdv: got %b expected 001", {d_readdatavalid, write, d_waitrequest});
    end
  endtask

  task automatic test_abort();
    reset_dut();
    f_address   = 32'h0000_0700;
    f_read      = 1'b1;
    waitrequest = 1'b1;
    step();
    #1;
    n_checks++;
    if ({read, f_waitrequest} !== 2'b11) begin
      n_fail++;
      $display("FAIL abort_busy: got %b expected 11", {read, f_waitrequest});
    end
    step();
    f_read = 1'b0;
    #1;
    n_checks++;
    if (read !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_drop: got %b expected 0", read);
    end
    step();
    f_read = 1'b1;
    #1;
    n_checks++;
    if ({read, f_waitrequest, f_readdatavalid} !== 3'b010) begin
      n_fail++;
      $display("FAIL abort_idle: got %b expected 010", {read, f_waitrequest, f_readdatavalid});
    end
  endtask

  task automatic test_back_to_back();
    reset_dut();
    d_address    = 32'h0000_0600;
    d_write      = 1'b1;
    d_writedata  = 32'h1111_1111;
    d_byteenable = 4'hF;
    waitrequest  = 1'b0;
    step();
    #1;
    n_checks++;
    if ({write, writedata} !== {1'b1, 32'h1111_1111}) begin
      n_fail++;
      $display("FAIL b2b_first: got %h expected %h", {write, writedata}, {1'b1, 32'h1111_1111});
    end
    step();
    d_address   = 32'h0000_0604;
    d_writedata = 32'h2222_2222;
    #1;
    n_checks++;
    if ({write, d_waitrequest} !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_gap: got %b expected 01", {write, d_waitrequest});
    end
    step();
    #1;
    n_checks++;
    if ({write, writedata, address, d_waitrequest} !== {1'b1, 32'h2222_2222, 32'h0000_0604, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_second: got %h expected %h", {write, writedata, address, d_waitrequest}, {1'b1, 32'h2222_2222, 32'h0000_0604, 1'b0});
    end
    step();
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_data_write_stall();
    test_fairness();
    test_watchdog();
    test_reset_in_resp_d();
    test_read_write_both();
    test_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
